// File: rtl/pwm_sample_scheduler.sv
// Frame-aligned sample scheduler feeding the PWM stage: small sample FIFO plus click-free ramp FSM.
// Define PWM_SCHED_RAMP_EN for per-frame RAMP_STEP ramps; otherwise the ramp states jump at one boundary.
module pwm_sample_scheduler #(
    parameter int unsigned DATA_WIDTH  = 12,
    parameter int unsigned COUNT_WIDTH = 10,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int          RAMP_STEP   = 16,
    parameter int          REST_VALUE  = -512
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [DATA_WIDTH-1:0]         s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [DATA_WIDTH-1:0]         pwm_data,
    output logic                          frame_start,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [1:0]                    state
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned SW = DATA_WIDTH + 1;
    localparam logic signed [SW-1:0]   REST_EXT  = SW'(REST_VALUE);
    localparam logic [DATA_WIDTH-1:0]  REST_DATA = REST_EXT[DATA_WIDTH-1:0];

    if (RAMP_STEP <= 0 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("pwm_sample_scheduler: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RUN       = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [COUNT_WIDTH-1:0]  count_q;
    logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0]   pwm_d;
    logic                    underrun_d;
    logic                    boundary, fifo_empty, fifo_full;
    logic                    push, pop, flush;

    assign boundary    = &count_q;
    assign frame_start = (count_q == '0);
    assign fifo_empty  = (fifo_level == '0);
    assign fifo_full   = (fifo_level == LW'(FIFO_DEPTH));
    assign s_ready     = ((state_q == RAMP_UP) || (state_q == RUN)) && !fifo_full;
    assign push        = s_valid && s_ready && !flush;
    assign state       = state_q;

`ifdef PWM_SCHED_RAMP_EN
    localparam logic signed [SW-1:0] STEP_EXT = SW'(RAMP_STEP);
    logic signed [SW-1:0] pwm_ext, up_sum, dn_sum;
    assign pwm_ext = signed'({pwm_data[DATA_WIDTH-1], pwm_data});
`endif

    // Next-state, frame actions and FIFO control
    always_comb begin
        state_d    = state_q;
        pwm_d      = pwm_data;
        underrun_d = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
`ifdef PWM_SCHED_RAMP_EN
        up_sum     = pwm_ext + STEP_EXT;
        dn_sum     = (pwm_ext > REST_EXT) ? (pwm_ext - STEP_EXT) : (pwm_ext + STEP_EXT);
`endif
        case (state_q)
            IDLE: begin
                flush = 1'b1;
                pwm_d = REST_DATA;
                if (enable) state_d = RAMP_UP;
            end
            RAMP_UP: begin
                if (!enable) begin
                    flush   = 1'b1;
                    state_d = RAMP_DOWN;
                end else if (boundary) begin
`ifdef PWM_SCHED_RAMP_EN
                    if (!up_sum[SW-1]) begin
                        pwm_d   = '0;
                        state_d = RUN;
                    end else begin
                        pwm_d = DATA_WIDTH'(up_sum);
                    end
`else
                    pwm_d   = '0;
                    state_d = RUN;
`endif
                end
            end
            RUN: begin
                if (!enable) begin
                    flush   = 1'b1;
                    state_d = RAMP_DOWN;
                end else if (boundary) begin
                    if (!fifo_empty) begin
                        pop   = 1'b1;
                        pwm_d = mem[rd_ptr];
                    end else begin
                        underrun_d = 1'b1;
                    end
                end
            end
            RAMP_DOWN: begin
                flush = 1'b1;
                if (boundary) begin
`ifdef PWM_SCHED_RAMP_EN
                    // Step toward rest from either side, saturating on arrival
                    if ((pwm_ext > REST_EXT) ? (dn_sum <= REST_EXT) : (dn_sum >= REST_EXT)) begin
                        pwm_d   = REST_DATA;
                        state_d = IDLE;
                    end else begin
                        pwm_d = DATA_WIDTH'(dn_sum);
                    end
`else
                    pwm_d   = REST_DATA;
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            pwm_data   <= REST_DATA;
            underrun   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_q + COUNT_WIDTH'(1);
            pwm_data <= pwm_d;
            underrun <= underrun_d;
            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_level <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                fifo_level <= fifo_level + LW'(push) - LW'(pop);
            end
        end
    end

    // Sample storage needs no reset; occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

endmodule

// File: tb/tb_pwm_sample_scheduler.sv
// Directed bench for pwm_sample_scheduler using a 16-cycle frame; follows PWM_SCHED_RAMP_EN if defined.
module tb_pwm_sample_scheduler;

    localparam int unsigned DW = 12;
    localparam int unsigned LW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] pwm_data;
    logic          frame_start;
    logic          underrun;
    logic [LW-1:0] fifo_level;
    logic [1:0]    state;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pwm_sample_scheduler #(
        .DATA_WIDTH (12),
        .COUNT_WIDTH(4),
        .FIFO_DEPTH (8),
        .RAMP_STEP  (256),
        .REST_VALUE (-512)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .pwm_data   (pwm_data),
        .frame_start(frame_start),
        .underrun   (underrun),
        .fifo_level (fifo_level),
        .state      (state)
    );

    function automatic logic [DW-1:0] d(input int v);
        return DW'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fs(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            if (frame_start) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        n_checks++; if (pwm_data !== d(-512)) $display("FAIL reset_pwm: got %0d want -512", $signed(pwm_data)); else n_pass++;
        n_checks++; if (state !== 2'd0) $display("FAIL reset_state: got %0d want 0", state); else n_pass++;
        n_checks++; if (s_ready !== 1'b0) $display("FAIL reset_s_ready: got %b want 0", s_ready); else n_pass++;
        n_checks++; if (fifo_level !== 4'd0) $display("FAIL reset_level: got %0d want 0", fifo_level); else n_pass++;
        n_checks++; if (frame_start !== 1'b1) $display("FAIL reset_frame_start: got %b want 1", frame_start); else n_pass++;
        n_checks++; if (underrun !== 1'b0) $display("FAIL reset_underrun: got %b want 0", underrun); else n_pass++;
    endtask

    task automatic test_ramp_up();
        bit ok;
        enable = 1'b1;
        tick();
        n_checks++; if (state !== 2'd1) $display("FAIL ramp_up_state: got %0d want 1", state); else n_pass++;
        n_checks++; if (s_ready !== 1'b1) $display("FAIL ramp_up_s_ready: got %b want 1", s_ready); else n_pass++;
`ifdef PWM_SCHED_RAMP_EN
        wait_fs(ok);
        n_checks++;
        if (!ok || pwm_data !== d(-256) || state !== 2'd1)
            $display("FAIL ramp_up_step1: got pwm=%0d state=%0d fs=%b want pwm=-256 state=1", $signed(pwm_data), state, ok);
        else n_pass++;
`endif
        wait_fs(ok);
        n_checks++;
        if (!ok || pwm_data !== d(0) || state !== 2'd2)
            $display("FAIL ramp_up_done: got pwm=%0d state=%0d fs=%b want pwm=0 state=2", $signed(pwm_data), state, ok);
        else n_pass++;
    endtask

    task automatic test_run_sequence();
        bit ok;
        int vals [3] = '{100, -200, 300};
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_data  = d(vals[i]);
            tick();
        end
        s_valid = 1'b0;
        n_checks++; if (fifo_level !== 4'd3) $display("FAIL run_level: got %0d want 3", fifo_level); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            wait_fs(ok);
            n_checks++;
            if (!ok || pwm_data !== d(vals[i]) || underrun !== 1'b0)
                $display("FAIL run_pop%0d: got pwm=%0d underrun=%b fs=%b want pwm=%0d underrun=0",
                         i, $signed(pwm_data), underrun, ok, vals[i]);
            else n_pass++;
        end
        wait_fs(ok);
        n_checks++;
        if (!ok || pwm_data !== d(300) || underrun !== 1'b1)
            $display("FAIL run_underrun: got pwm=%0d underrun=%b fs=%b want pwm=300 underrun=1", $signed(pwm_data), underrun, ok);
        else n_pass++;
        tick();
        n_checks++; if (underrun !== 1'b0) $display("FAIL run_underrun_pulse: got %b want 0", underrun); else n_pass++;
    endtask

    task automatic test_ramp_down();
        bit ok;
`ifdef PWM_SCHED_RAMP_EN
        int exp_pwm [4] = '{44, -212, -468, -512};
`endif
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data  = d(7 * i);
            tick();
        end
        s_valid = 1'b0;
        n_checks++;
        if (fifo_level !== 4'd5 || pwm_data !== d(300))
            $display("FAIL down_pre: got level=%0d pwm=%0d want level=5 pwm=300", fifo_level, $signed(pwm_data));
        else n_pass++;
        enable = 1'b0;
        tick();
        n_checks++; if (state !== 2'd3) $display("FAIL down_state: got %0d want 3", state); else n_pass++;
        n_checks++; if (fifo_level !== 4'd0) $display("FAIL down_flush: got %0d want 0", fifo_level); else n_pass++;
        n_checks++; if (s_ready !== 1'b0) $display("FAIL down_s_ready: got %b want 0", s_ready); else n_pass++;
`ifdef PWM_SCHED_RAMP_EN
        for (int i = 0; i < 4; i++) begin
            wait_fs(ok);
            n_checks++;
            if (!ok || pwm_data !== d(exp_pwm[i]) || state !== ((i == 3) ? 2'd0 : 2'd3))
                $display("FAIL down_step%0d: got pwm=%0d state=%0d fs=%b want pwm=%0d", i, $signed(pwm_data), state, ok, exp_pwm[i]);
            else n_pass++;
        end
`else
        wait_fs(ok);
        n_checks++;
        if (!ok || pwm_data !== d(-512) || state !== 2'd0)
            $display("FAIL down_jump: got pwm=%0d state=%0d fs=%b want pwm=-512 state=0", $signed(pwm_data), state, ok);
        else n_pass++;
`endif
    endtask

    task automatic test_fill();
        bit ok;
        enable = 1'b1;
        tick();
        ok = 1'b1;
        for (int f = 0; f < 3 && state !== 2'd2; f++) wait_fs(ok);
        n_checks++;
        if (!ok || state !== 2'd2 || pwm_data !== d(0) || frame_start !== 1'b1)
            $display("FAIL fill_restart: got state=%0d pwm=%0d fs=%b want state=2 pwm=0 fs=1", state, $signed(pwm_data), frame_start);
        else n_pass++;
        for (int i = 0; i < 9; i++) begin
            s_valid = 1'b1;
            s_data  = d(1000 + i);
            n_checks++;
            if (s_ready !== (i < 8)) $display("FAIL fill_ready%0d: got %b want %b", i, s_ready, (i < 8));
            else n_pass++;
            tick();
        end
        s_valid = 1'b0;
        n_checks++; if (fifo_level !== 4'd8) $display("FAIL fill_level: got %0d want 8", fifo_level); else n_pass++;
        wait_fs(ok);
        n_checks++;
        if (!ok || pwm_data !== d(1000) || fifo_level !== 4'd7)
            $display("FAIL fill_first_pop: got pwm=%0d level=%0d fs=%b want pwm=1000 level=7", $signed(pwm_data), fifo_level, ok);
        else n_pass++;
    endtask

    task automatic test_midrun_reset();
        bit ok;
        bit all_ok = 1'b1;
        for (int f = 0; f < 4; f++) begin
            wait_fs(ok);
            all_ok &= ok;
        end
        n_checks++;
        if (!all_ok || fifo_level !== 4'd3 || pwm_data !== d(1004))
            $display("FAIL mid_pre: got level=%0d pwm=%0d want level=3 pwm=1004", fifo_level, $signed(pwm_data));
        else n_pass++;
        rst_n  = 1'b0;
        enable = 1'b0;
        tick();
        n_checks++;
        if (pwm_data !== d(-512) || state !== 2'd0 || fifo_level !== 4'd0 || s_ready !== 1'b0 || underrun !== 1'b0)
            $display("FAIL mid_reset: got pwm=%0d state=%0d level=%0d s_ready=%b underrun=%b want -512/0/0/0/0",
                     $signed(pwm_data), state, fifo_level, s_ready, underrun);
        else n_pass++;
        rst_n = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (state !== 2'd0 || s_ready !== 1'b0)
            $display("FAIL mid_idle: got state=%0d s_ready=%b want 0/0", state, s_ready);
        else n_pass++;
        enable = 1'b1;
        tick();
        n_checks++;
        if (state !== 2'd1 || s_ready !== 1'b1)
            $display("FAIL mid_restart: got state=%0d s_ready=%b want 1/1", state, s_ready);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_run_sequence();
        test_ramp_down();
        test_fill();
        test_midrun_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pwm_sample_scheduler.md
# pwm_sample_scheduler

Sequences audio samples from the demodulator into the `PWM` output stage. Buffers incoming samples in a small FIFO and presents exactly one sample per PWM frame, aligned to frame boundaries. Ramps the output between a rest level and midscale on enable/disable so the speaker path sees no click. Sits between the demodulator/decimator output stream and the `PWM` block's `data_in`.

## Interface

Parameters:
- `DATA_WIDTH`, 12, sample width, signed two's complement; matches `PWM` data width.
- `COUNT_WIDTH`, 10, frame counter width; frame length is 2^COUNT_WIDTH cycles; matches `PWM` counter.
- `FIFO_DEPTH`, 8, sample FIFO depth; power of two, at least 2.
- `RAMP_STEP`, 16, magnitude of the per-frame ramp increment; positive.
- `REST_VALUE`, -512, signed output value in IDLE; gives ~0% duty after `PWM` adds its offset.

Ports:
- `clk` in 1: single clock for all logic.
- `rst_n` in 1: synchronous, active-low reset.
- `enable` in 1: level; 1 requests playback, 0 requests shutdown.
- `s_data` in DATA_WIDTH: signed input sample.
- `s_valid` in 1: `s_data` valid.
- `s_ready` out 1: scheduler accepts a sample this cycle.
- `pwm_data` out DATA_WIDTH: registered sample to `PWM.data_in`.
- `frame_start` out 1: high in the cycle where the frame counter equals 0.
- `underrun` out 1: one-cycle pulse when RUN finds the FIFO empty at a boundary.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `state` out 2: IDLE=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3.

## Operation

- The frame counter increments every cycle and wraps from 2^COUNT_WIDTH-1 to 0.
- A "boundary" is a clock edge where the counter equals 2^COUNT_WIDTH-1. All `pwm_data` updates and FSM frame actions happen only on boundaries.
- Input handshake: a sample transfers when `s_valid && s_ready`. `s_ready = !full` in RAMP_UP and RUN; it is 0 in IDLE and RAMP_DOWN.
- A push and a pop in the same cycle leave `fifo_level` unchanged. Samples are read out in FIFO order.
- IDLE: `pwm_data = REST_VALUE`; the FIFO is held empty. When `enable=1`, the FSM moves to RAMP_UP on the next edge, without waiting for a boundary.
- RAMP_UP: on each boundary, `pwm_data += RAMP_STEP`, clamped at 0. The boundary that produces 0 also moves the FSM to RUN. The FIFO may prefill during RAMP_UP.
- RUN: on each boundary, a non-empty FIFO pops its head into `pwm_data`. An empty FIFO leaves `pwm_data` unchanged and pulses `underrun`.
- `enable=0` while in RAMP_UP or RUN moves the FSM to RAMP_DOWN on the next edge. The FIFO is flushed on that same edge, so `fifo_level=0` in the following cycle.
- RAMP_DOWN: on each boundary, `pwm_data` steps toward `REST_VALUE` by `RAMP_STEP`, saturating at `REST_VALUE`. Reaching `REST_VALUE` moves the FSM to IDLE. `enable` is ignored until IDLE is reached; no abort back to RAMP_UP.
- Arithmetic: ramp sums are computed at DATA_WIDTH+1 bits with a signed compare against the target, then clamped. No wrap is permitted.

## Timing

- Reset values: `pwm_data = REST_VALUE`, state IDLE, counter 0, FIFO empty, `s_ready=0`, `underrun=0`, `fifo_level=0`.
- `frame_start` is high in the first cycle after reset release.
- A new `pwm_data` value is visible in the same cycle `frame_start` is high. This matches `PWM` latching `data_in` when its own count is 0, provided both blocks leave reset together.
- Latency from a sample accepted into an empty FIFO in RUN to `pwm_data`: the next boundary; worst case 2^COUNT_WIDTH cycles.
- `underrun` goes high in the `frame_start` cycle and lasts one cycle.
- `rst_n=0` in any state restores all reset values on the next edge. In-flight FIFO contents are discarded.

## Configuration

- `PWM_SCHED_RAMP_EN` defined: RAMP_UP and RAMP_DOWN step by `RAMP_STEP` per frame, as described above.
- `PWM_SCHED_RAMP_EN` undefined: ramp logic is removed. RAMP_UP and RAMP_DOWN each last until the next boundary, where `pwm_data` jumps directly to 0 (RAMP_UP) or to `REST_VALUE` (RAMP_DOWN). All other behaviour is unchanged.

## Test plan

All scenarios use COUNT_WIDTH=4 (16-cycle frame), FIFO_DEPTH=8, RAMP_STEP=256, REST_VALUE=-512, with the ramp macro defined unless stated.

- Reset held, then released -> `pwm_data=-512`, state=0, `s_ready=0`, `fifo_level=0`, `frame_start` high in the first cycle after release.
- `enable=1` -> state=1; `pwm_data` reads -256 at the next `frame_start`, then 0 with state=2. With the macro undefined -> 0 at the first `frame_start`.
- In RUN, push 100, -200, 300 -> `pwm_data` reads 100, -200, 300 on three successive `frame_start` cycles. The fourth holds 300 with a one-cycle `underrun` pulse.
- In RUN, hold `s_valid=1` for 9 cycles within one frame -> 8 samples accepted, `s_ready=0` on the 9th cycle, `fifo_level=8`.
- `pwm_data=300`, `fifo_level=5`, drop `enable` -> `fifo_level=0` next cycle. `pwm_data` then reads 44, -212, -468, -512 on successive boundaries, then state=0.
- Assert `rst_n=0` for one cycle mid-RUN with `fifo_level=3` -> all reset values on the next edge; `s_ready=0` until `enable` restarts the sequence.
